// File: rtl/comp_frame_max.sv
// Frame reducer behind the 4-bit comparator: per-frame unsigned/signed
// maxima of the comparator winners, beat count and verdict-mismatch count.
module comp_frame_max #(
  parameter int W    = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            ans1,
  input  logic            ans2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_umax,
  output logic [W-1:0]    out_smax,
  output logic [CNTW-1:0] out_beats,
  output logic [CNTW-1:0] out_mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]    uw;
  logic [W-1:0]    sw;
  logic            mis;
  logic            take;

  logic [W-1:0]    umax_q;
  logic [W-1:0]    smax_q;
  logic [CNTW-1:0] beats_q;
  logic [CNTW-1:0] mism_q;

  logic [W-1:0]    umax_d;
  logic [W-1:0]    smax_d;
  logic [CNTW-1:0] beats_d;
  logic [CNTW-1:0] mism_d;

  function automatic logic [CNTW-1:0] sat_inc(
    input logic [CNTW-1:0] c,
    input logic            inc
  );
    if (inc && (c != '1)) begin
      return c + CNTW'(1);
    end
    return c;
  endfunction

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign take      = in_valid & in_ready;

  // Comparator flags are taken as the verdict; a and b are only selected.
  assign uw  = ans1 ? a : b;
  assign sw  = ans2 ? a : b;
  assign mis = ans1 ^ ans2;

  always_comb begin
    umax_d  = umax_q;
    smax_d  = smax_q;
    beats_d = beats_q;
    mism_d  = mism_q;
    if (state == IDLE) begin
      umax_d  = uw;
      smax_d  = sw;
      beats_d = CNTW'(1);
      mism_d  = CNTW'(mis);
    end else begin
      if (uw > umax_q) begin
        umax_d = uw;
      end
      if ($signed(sw) > $signed(smax_q)) begin
        smax_d = sw;
      end
      beats_d = sat_inc(beats_q, 1'b1);
      mism_d  = sat_inc(mism_q, mis);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE),
      (state == ACC): begin
        if (take) begin
          state_nxt = in_last ? HOLD : ACC;
        end
      end
      (state == HOLD): begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      umax_q  <= '0;
      smax_q  <= '0;
      beats_q <= '0;
      mism_q  <= '0;
    end else if (take) begin
      umax_q  <= umax_d;
      smax_q  <= smax_d;
      beats_q <= beats_d;
      mism_q  <= mism_d;
    end
  end

  // Results land on the edge that accepts the last beat and then hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_umax     <= '0;
      out_smax     <= '0;
      out_beats    <= '0;
      out_mismatch <= '0;
    end else if (take && in_last) begin
      out_umax     <= umax_d;
      out_smax     <= smax_d;
      out_beats    <= beats_d;
      out_mismatch <= mism_d;
    end
  end

endmodule

// File: tb/tb_comp_frame_max.sv
// Randomised bench for comp_frame_max against a frame-level reference
// model built from queued beats.
module tb_comp_frame_max;
  localparam int W    = 4;
  localparam int CNTW = 8;
  localparam int CMAX = 2**CNTW - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic            ans1 = 1'b0;
  logic            ans2 = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_umax;
  logic [W-1:0]    out_smax;
  logic [CNTW-1:0] out_beats;
  logic [CNTW-1:0] out_mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comp_frame_max #(.W(W), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a(a), .b(b), .ans1(ans1), .ans2(ans2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_umax(out_umax), .out_smax(out_smax),
    .out_beats(out_beats), .out_mismatch(out_mismatch)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         f1;
    logic         f2;
  } beat_t;

  beat_t fq[$];
  logic [W-1:0]    e_umax, e_smax;
  logic [CNTW-1:0] e_beats, e_mism;

  function automatic beat_t mk(int va, int vb, bit f1, bit f2);
    beat_t t;
    t.a = W'(va); t.b = W'(vb); t.f1 = f1; t.f2 = f2;
    return t;
  endfunction

  function automatic int sval(logic [W-1:0] v);
    int u = int'(v);
    return (u >= 2**(W-1)) ? u - 2**W : u;
  endfunction

  task automatic model();
    int um = 0, sm = 0, nb = 0, nm = 0;
    logic [W-1:0] uw, sw;
    foreach (fq[i]) begin
      uw = fq[i].f1 ? fq[i].a : fq[i].b;
      sw = fq[i].f2 ? fq[i].a : fq[i].b;
      if (i == 0 || int'(uw) > um) um = int'(uw);
      if (i == 0 || sval(sw) > sm) begin
        sm = sval(sw);
        e_smax = sw;
      end
      nb++;
      if (fq[i].f1 != fq[i].f2) nm++;
    end
    e_umax  = W'(um);
    e_beats = CNTW'(nb > CMAX ? CMAX : nb);
    e_mism  = CNTW'(nm > CMAX ? CMAX : nm);
  endtask

  task automatic send_beat(beat_t t, logic last);
    int n = 0;
    in_valid = 1'b1; in_last = last;
    a = t.a; b = t.b; ans1 = t.f1; ans2 = t.f2;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fq[i]) send_beat(fq[i], i == fq.size() - 1);
    model();
  endtask

  task automatic handshake(int d);
    repeat (d) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_frame(string name);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: out_valid=%0b, need 1", name, out_valid);
    end
    n_checks++;
    if ({out_umax, out_smax, out_beats, out_mismatch} !== {e_umax, e_smax, e_beats, e_mism}) begin
      n_fail++;
      $display("FAIL %s_data: got u=%0d s=%0d n=%0d m=%0d, need u=%0d s=%0d n=%0d m=%0d",
               name, out_umax, out_smax, out_beats, out_mismatch, e_umax, e_smax, e_beats, e_mism);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid=%0b in_ready=%0b, need 0 1", out_valid, in_ready);
    end
    n_checks++;
    if ({out_umax, out_smax, out_beats, out_mismatch} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d %0d %0d %0d, need 0", out_umax, out_smax, out_beats, out_mismatch);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    fq = {mk(7, 8, 0, 1)};
    send_frame();
    chk_frame("single");
    handshake(0);
  endtask

  task automatic test_two_beat();
    fq = {mk(7, 8, 0, 1), mk(3, 2, 1, 1)};
    send_frame();
    chk_frame("two_beat");
    handshake(0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL two_beat_drop: out_valid=%0b in_ready=%0b, need 0 1", out_valid, in_ready);
    end
    n_checks++;
    if ({out_umax, out_smax, out_beats, out_mismatch} !== {e_umax, e_smax, e_beats, e_mism}) begin
      n_fail++;
      $display("FAIL two_beat_held: got u=%0d s=%0d n=%0d m=%0d after handshake",
               out_umax, out_smax, out_beats, out_mismatch);
    end
  endtask

  task automatic test_signed();
    fq = {mk(15, 1, 1, 0), mk(9, 9, 0, 0)};
    send_frame();
    chk_frame("signed");
    handshake(2);
  endtask

  task automatic test_idle_ready();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_ready: out_valid=%0b in_ready=%0b, need 0 1", out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    beat_t p;
    fq = {mk(5, 3, 1, 1)};
    send_frame();
    p = mk(2, 12, 0, 1);
    in_valid = 1'b1; in_last = 1'b1;
    a = p.a; b = p.b; ans1 = p.f1; ans2 = p.f2;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready: cycle %0d in_ready=%0b, need 0", i, in_ready);
      end
      chk_frame("stall_hold");
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hs_ready: in_ready=%0b in handshake, need 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_idle: out_valid=%0b in_ready=%0b, need 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    fq = {p};
    model();
    chk_frame("stall_pending");
    handshake(1);
  endtask

  task automatic test_saturation();
    fq = {};
    for (int i = 0; i < 301; i++) fq.push_back(mk(1, 2, 0, 0));
    send_frame();
    chk_frame("sat_beats");
    handshake(0);
    fq = {};
    for (int i = 0; i < 280; i++) fq.push_back(mk(i % 16, 6, 1, 0));
    send_frame();
    chk_frame("sat_mism");
    handshake(0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) send_beat(mk(9 + i, 2, 1, 1), 1'b0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {out_umax, out_smax, out_beats, out_mismatch} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: v=%0b r=%0b u=%0d s=%0d n=%0d m=%0d, need 0 1 0 0 0 0",
               out_valid, in_ready, out_umax, out_smax, out_beats, out_mismatch);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    fq = {mk(4, 5, 0, 0)};
    send_frame();
    chk_frame("post_reset");
    handshake(0);
  endtask

  task automatic test_random();
    int len;
    int va, vb;
    for (int f = 0; f < 25; f++) begin
      fq = {};
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        va = $urandom_range(0, 15);
        vb = $urandom_range(0, 15);
        if ($urandom_range(0, 3) != 0)
          fq.push_back(mk(va, vb, va > vb, sval(W'(va)) > sval(W'(vb))));
        else
          fq.push_back(mk(va, vb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1));
      end
      send_frame();
      chk_frame("random");
      handshake($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_beat();
    test_signed();
    test_idle_ready();
    test_hold_stall();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_frame_max.md
Name: comp_frame_max

Overview:
- Downstream consumer of the 4-bit unsigned/signed comparator stage. Each beat carries operands a, b and the comparator's two greater-than flags.
- Per beat, the block picks the unsigned winner and the signed winner. Across a frame (delimited by in_last) it tracks the running unsigned maximum and the running signed maximum, counts beats, and counts beats where the signed and unsigned verdicts disagree.
- Frame results are returned over a valid/ready handshake.

Parameters:
- W, 4, operand width; must match the comparator operand width.
- CNTW, 8, width of the beat and mismatch counters.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  qualifies the final beat of a frame.
- a  in  W  operand a, as presented to the comparator.
- b  in  W  operand b, as presented to the comparator.
- ans1  in  1  comparator result: a > b, unsigned.
- ans2  in  1  comparator result: a > b, signed (two's complement).
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_umax  out  W  unsigned maximum over the unsigned winners of the frame.
- out_smax  out  W  signed maximum over the signed winners of the frame (two's complement bit pattern).
- out_beats  out  CNTW  number of beats in the frame; saturating.
- out_mismatch  out  CNTW  number of beats with ans1 != ans2; saturating.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, out_valid=0. All out_* registers and internal accumulators clear to 0.
- Accept rule: a beat is taken when in_valid & in_ready. in_ready=1 in IDLE and ACC, 0 in HOLD.
- Per-beat winners:
  - uw = ans1 ? a : b.
  - sw = ans2 ? a : b.
  - ans1/ans2 are trusted as given and never recomputed from a, b.
- Running maxima:
  - The unsigned running max uses an unsigned compare.
  - The signed running max uses a two's-complement compare.
  - Ties keep the held value.
- FSM:
  - IDLE, accepted beat: load umax=uw, smax=sw, beats=1, mism=(ans1^ans2). If in_last, go to HOLD, else go to ACC.
  - ACC, accepted beat: umax=max_u(umax,uw), smax=max_s(smax,sw), beats+=1, mism+=(ans1^ans2), each counter saturating at 2^CNTW-1. If in_last, go to HOLD, else stay in ACC.
  - ACC, no beat: hold all state.
  - HOLD: out_valid=1 with out_* stable. Stay until out_ready=1; that cycle is the handshake, and the next cycle is IDLE with out_valid=0 and in_ready=1.
- Latency and output timing:
  - The result is registered. out_valid rises in the cycle after the last beat is accepted, and out_* are updated in that same edge.
  - No combinational path from in_* to out_*.
  - No bypass: in_ready stays 0 during the handshake cycle.
- out_* hold the last frame's values after the handshake until the next frame completes.
- Single-beat frame (first beat has in_last=1): output is uw, sw, beats=1, mism=0 or 1.
- out_ready high while out_valid=0: ignored.
- in_valid while in_ready=0: not consumed; upstream must hold the beat.
- Counter saturation: at 2^CNTW-1 a counter holds; the maxima keep updating.
- Reset asserted mid-frame or in HOLD: the frame is discarded and the block returns to the reset state immediately.

Test Plan:
- Reset, then one beat a=7, b=8, ans1=0, ans2=1, last=1 -> next cycle out_valid=1, out_umax=8, out_smax=7, out_beats=1, out_mismatch=1.
- Frame (7,8,0,1), (3,2,1,1,last), out_ready=1 -> out_umax=8, out_smax=7, out_beats=2, out_mismatch=1; out_valid drops the cycle after the handshake.
- Frame (15,1,1,0), (9,9,0,0,last) -> uw sequence 15,9 and sw sequence 1,9 (9 = -7 signed) -> out_umax=15, out_smax=1, out_mismatch=1.
- HOLD with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0 and out_* stable for all 5 cycles; no beat consumed. Raise out_ready -> IDLE; the pending beat is accepted the next cycle.
- CNTW=8, 300 beats of (1,2,0,0), then last -> out_beats=255 and out_mismatch=0, both saturated/held.
- reset=0 pulsed asynchronously mid-frame after 3 beats -> outputs clear immediately. Then a 1-beat frame (4,5,0,0,last) -> out_umax=5, out_smax=5, out_beats=1.
